imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the core's immediate extender: packs a 32-bit immediate into the RISC-V instruction bit positions for the format selected by EXTop, merged into a caller-supplied instruction template.
- Used by the debug instruction injector and the test program builder.
- Two-stage valid/ready pipeline with full backpressure.
- Flags immediates not representable in the selected format and counts them.

Parameters:
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  block accepts request this cycle
- EXTop  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal
- imm  input  32  immediate value, two's complement
- tmpl  input  32  instruction template; immediate-bearing bits are overwritten
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- inst  output  32  encoded instruction
- err  output  1  immediate not encodable; qualified by out_valid
- err_cnt  output  CNT_W  count of errored results delivered
- cnt_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Reset (async, active-high), outputs and state:
  - Both stage valid flags = 0, so out_valid=0.
  - inst = 0, err = 0, err_cnt = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
  - Asserting rst mid-operation discards all in-flight requests and delivers no output.
- Handshake:
  - Transfer occurs when valid && ready in the same cycle.
  - in_valid, EXTop, imm and tmpl are sampled only on an input transfer.
  - out_valid stays high with inst/err stable until an output transfer.
- Pipeline:
  - Stage A registers the request and computes the range check and bit scatter.
  - Stage B is the output register.
  - B_ready = !B_valid || out_ready; in_ready = !A_valid || B_ready.
  - in_ready is purely combinational from out_ready and state; no dependence on in_valid.
  - Latency: accept at cycle N gives out_valid at N+2 when unstalled.
  - Throughput: 1 per cycle; order preserved; no drops or duplicates under any out_ready pattern.
- Encoding (all bits not listed are taken from tmpl):
  - I: inst[31:20] = imm[11:0]. Legal iff imm is in -2048..2047.
  - S: inst[31:25] = imm[11:5], inst[11:7] = imm[4:0]. Same legal range as I.
  - B: inst[31] = imm[12], inst[7] = imm[11], inst[30:25] = imm[10:5], inst[11:8] = imm[4:1]. Legal iff imm is in -4096..4094 and imm[0] = 0.
  - U: inst[31:12] = imm[31:12]. Legal iff imm[11:0] = 0.
  - J: inst[31] = imm[20], inst[19:12] = imm[19:12], inst[20] = imm[11], inst[30:21] = imm[10:1]. Legal iff imm is in -1048576..1048574 and imm[0] = 0.
  - Illegal EXTop (101-111): err = 1.
  - Whenever err = 1, inst = tmpl unchanged.
- Range checks are signed comparisons on the full 32 bits, with no truncation before the check.
- Round-trip invariant: for every legal request, passing inst through the core's immediate extender with the same EXTop returns imm.
- err_cnt:
  - Increments on each output transfer with err = 1.
  - Saturates at all-ones.
  - If cnt_clr and an errored transfer occur in the same cycle, the result is 1.
  - cnt_clr alone gives 0.

Test Plan:
- I-type, imm=0xFFFFFFFF, tmpl=0x00000013, out_ready=1 -> inst=0xFFF00013, err=0, out_valid exactly 2 cycles after accept.
- B-type, imm=8, tmpl=0x00000063 -> inst=0x00000463, err=0. B-type, imm=3 -> err=1, inst=0x00000063, err_cnt=1.
- J-type, imm=0x800, tmpl=0x0000006F -> inst=0x0010006F. U-type, imm=0x12345000, tmpl=0x00000037 -> inst=0x12345037. U-type, imm=0x12345001 -> err=1.
- I-type imm=2048, S-type imm=-2049 and EXTop=110 -> three results, all err=1, inst=tmpl; err_cnt=3. Then cnt_clr -> err_cnt=0. Preload err_cnt to 0xFFFF and send one error -> stays 0xFFFF.
- Backpressure:
  - Stimulus: in_valid=1 with 4 back-to-back requests, out_ready=0 for 4 cycles, then 1.
  - Required: in_ready falls after 2 accepts; outputs hold stable; all 4 results emerge in order with no loss.
  - Also run a random out_ready pattern over 1000 random requests, checked against a round-trip reference model.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between clock edges) with 2 requests in flight.
  - Required: out_valid=0 and err_cnt=0 immediately; after release no stale result appears; in_ready=1.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into the RISC-V bit positions of the
// selected format over a caller template, with range checking and a saturating error count.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       EXTop,
    input  logic [31:0]      imm,
    input  logic [31:0]      tmpl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    localparam logic [2:0] OP_I = 3'b000;
    localparam logic [2:0] OP_S = 3'b001;
    localparam logic [2:0] OP_B = 3'b010;
    localparam logic [2:0] OP_U = 3'b011;
    localparam logic [2:0] OP_J = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               a_valid;
    logic [2:0]         a_op;
    logic [31:0]        a_imm;
    logic [31:0]        a_tmpl;
    logic signed [31:0] s_imm;
    logic [31:0]        enc_inst;
    logic               enc_legal;

    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_inst;
    logic        b_err;

    assign b_ready   = !b_valid || out_ready;
    assign in_ready  = !a_valid || b_ready;
    assign out_valid = b_valid;
    assign inst      = b_inst;
    assign err       = b_err;
    assign s_imm     = $signed(a_imm);

    // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid <= 1'b0;
        end else if (in_ready) begin
            a_valid <= in_valid;
        end
    end

    // NOTE: the request payload is deliberately not reset; it is only ever consumed while a_valid is set.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            a_op   <= EXTop;
            a_imm  <= imm;
            a_tmpl <= tmpl;
        end
    end

    // Range checks are on the full signed value, before any field is cut out of it.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        enc_inst  = a_tmpl;
        enc_legal = 1'b0;
        case (a_op)
            OP_I: begin
                enc_inst[31:20] = a_imm[11:0];
                enc_legal       = (s_imm >= -32'sd2048) && (s_imm <= 32'sd2047);
            end
            OP_S: begin
                enc_inst[31:25] = a_imm[11:5];
                enc_inst[11:7]  = a_imm[4:0];
                enc_legal       = (s_imm >= -32'sd2048) && (s_imm <= 32'sd2047);
            end
            OP_B: begin
                enc_inst[31]    = a_imm[12];
                enc_inst[7]     = a_imm[11];
                enc_inst[30:25] = a_imm[10:5];
                enc_inst[11:8]  = a_imm[4:1];
                enc_legal       = (s_imm >= -32'sd4096) && (s_imm <= 32'sd4094) && !a_imm[0];
            end
            OP_U: begin
                enc_inst[31:12] = a_imm[31:12];
                enc_legal       = (a_imm[11:0] == 12'd0);
            end
            OP_J: begin
                enc_inst[31]    = a_imm[20];
                enc_inst[19:12] = a_imm[19:12];
                enc_inst[20]    = a_imm[11];
                enc_inst[30:21] = a_imm[10:1];
                enc_legal       = (s_imm >= -32'sd1048576) && (s_imm <= 32'sd1048574) && !a_imm[0];
            end
            default: ;
        endcase
        if (!enc_legal) begin
            enc_inst = a_tmpl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_inst  <= '0;
            b_err   <= 1'b0;
        end else if (b_ready) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_inst <= enc_inst;
                b_err  <= !enc_legal;
            end
        end
    end

    // A clear coinciding with an errored delivery leaves exactly that one error counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (b_valid && out_ready && b_err) begin
            if (cnt_clr) begin
                err_cnt <= CNT_ONE;
            end else if (!(&err_cnt)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed format cases, error counting, backpressure, mid-flight reset,
// and a randomized run scored by decoding each result back through the immediate extender.
module tb_imm_encoder;

    localparam int CNT_W = 16;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] tmpl;
    } req_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       EXTop;
    logic [31:0]      imm;
    logic [31:0]      tmpl;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             cnt_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_encoder #(.CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .EXTop    (EXTop),
        .imm      (imm),
        .tmpl     (tmpl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .inst     (inst),
        .err      (err),
        .err_cnt  (err_cnt),
        .cnt_clr  (cnt_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The core's immediate extender, used as the round-trip oracle.
    function automatic logic [31:0] decode(input logic [2:0] op, input logic [31:0] i);
        case (op)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] fmt_mask(input logic [2:0] op);
        case (op)
            3'd0:       return 32'hFFF0_0000;
            3'd1, 3'd2: return 32'hFE00_0F80;
            3'd3, 3'd4: return 32'hFFFF_F000;
            default:    return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic legal(input logic [2:0] op, input logic [31:0] im);
        longint v;
        v = longint'($signed(im));
        case (op)
            3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
            3'd2:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            3'd3:       return (v % 4096 == 0);
            3'd4:       return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        int v;
        int b;
        case ($urandom_range(0, 4))
            0: v = int'($urandom);
            1: v = int'($urandom_range(0, 10000)) - 5000;
            2: v = ($urandom_range(0, 1) != 0 ? 1048576 : -1048576) + int'($urandom_range(0, 8)) - 4;
            3: v = int'($urandom & 32'hFFFF_F000) + ($urandom_range(0, 3) == 0 ? 1 : 0);
            default: begin
                b = ($urandom_range(0, 1) != 0) ? 2048 : 4096;
                v = ($urandom_range(0, 1) != 0 ? b : -b) + int'($urandom_range(0, 4)) - 2;
            end
        endcase
        return 32'(v);
    endfunction

    task automatic check_result(input req_t r, input logic [31:0] o, input logic e);
        logic        lg;
        logic [31:0] m;
        lg = legal(r.op, r.imm);
        m  = fmt_mask(r.op);
        check("rnd_err", 32'(e), 32'(!lg));
        if (lg) begin
            check("rnd_roundtrip", decode(r.op, o), r.imm);
            check("rnd_tmpl_bits", o & ~m, r.tmpl & ~m);
        end else begin
            check("rnd_err_tmpl", o, r.tmpl);
        end
    endtask

    // Single request through an empty pipeline, with latency checked on the way.
    task automatic xfer(input logic [2:0] op, input logic [31:0] im, input logic [31:0] t,
                        input logic clr, output logic [31:0] o_inst, output logic o_err);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        EXTop     = op;
        imm       = im;
        tmpl      = t;
        #1;
        check("xfer_in_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        tick;
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        o_inst  = inst;
        o_err   = err;
        cnt_clr = clr;
        tick;
        cnt_clr = 1'b0;
        check("xfer_drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ri;
        logic        re;
        logic [31:0] held;
        int          k;
        int          got;
        int          accepted;
        int          cyc;
        req_t        q[$];
        req_t        r;
        logic        hold_v;
        logic [31:0] hold_inst;
        logic        hold_err;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        EXTop     = '0;
        imm       = '0;
        tmpl      = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        xfer(3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0, ri, re);
        check("i_neg1_inst", ri, 32'hFFF0_0013);
        check("i_neg1_err", 32'(re), 32'd0);
        xfer(3'b010, 32'd8, 32'h0000_0063, 1'b0, ri, re);
        check("b_8_inst", ri, 32'h0000_0463);
        check("b_8_err", 32'(re), 32'd0);
        xfer(3'b010, 32'd3, 32'h0000_0063, 1'b0, ri, re);
        check("b_3_inst", ri, 32'h0000_0063);
        check("b_3_err", 32'(re), 32'd1);
        check("b_3_cnt", 32'(err_cnt), 32'd1);
        xfer(3'b100, 32'h0000_0800, 32'h0000_006F, 1'b0, ri, re);
        check("j_800_inst", ri, 32'h0010_006F);
        check("j_800_err", 32'(re), 32'd0);
        xfer(3'b011, 32'h1234_5000, 32'h0000_0037, 1'b0, ri, re);
        check("u_ok_inst", ri, 32'h1234_5037);
        xfer(3'b011, 32'h1234_5001, 32'h0000_0037, 1'b0, ri, re);
        check("u_bad_err", 32'(re), 32'd1);
        check("u_bad_inst", ri, 32'h0000_0037);

        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(err_cnt), 32'd0);
        xfer(3'b000, 32'd2048, 32'h0000_0013, 1'b0, ri, re);
        check("i_2048_err", 32'(re), 32'd1);
        check("i_2048_inst", ri, 32'h0000_0013);
        xfer(3'b001, 32'hFFFF_F7FF, 32'h0000_0023, 1'b0, ri, re);
        check("s_m2049_err", 32'(re), 32'd1);
        check("s_m2049_inst", ri, 32'h0000_0023);
        xfer(3'b110, 32'd0, 32'hDEAD_BEEF, 1'b0, ri, re);
        check("op110_err", 32'(re), 32'd1);
        check("op110_inst", ri, 32'hDEAD_BEEF);
        check("cnt_three", 32'(err_cnt), 32'd3);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        check("clr_cnt2", 32'(err_cnt), 32'd0);

        xfer(3'b111, 32'd0, 32'd0, 1'b0, ri, re);
        xfer(3'b111, 32'd0, 32'd0, 1'b0, ri, re);
        check("cnt_two", 32'(err_cnt), 32'd2);
        xfer(3'b111, 32'd0, 32'd0, 1'b1, ri, re);
        check("clr_with_err", 32'(err_cnt), 32'd1);

        // Saturation: fill the counter with a continuous stream of errors.
        cnt_clr = 1'b1;
        tick;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        EXTop     = 3'b111;
        in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        check("sat_full", 32'(err_cnt), 32'h0000_FFFF);
        xfer(3'b101, 32'd0, 32'd0, 1'b0, ri, re);
        check("sat_hold", 32'(err_cnt), 32'h0000_FFFF);

        // Backpressure: four requests against a stalled consumer.
        k         = 0;
        got       = 0;
        held      = '0;
        out_ready = 1'b0;
        EXTop     = 3'b000;
        tmpl      = 32'h0000_0013;
        for (int c = 0; c < 4; c++) begin
            in_valid = (k < 4);
            imm      = 32'(k + 1);
            #1;
            if (in_ready) k++;
            tick;
            if (c == 2) held = inst;
            if (c == 3) check("bp_hold", inst, held);
        end
        check("bp_accepts", 32'(k), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (k < 4);
            imm      = 32'(k + 1);
            #1;
            if (in_valid && in_ready) k++;
            if (out_valid) begin
                check("bp_order", inst, (32'(got + 1) << 20) | 32'h0000_0013);
                got++;
            end
            tick;
        end
        in_valid = 1'b0;
        check("bp_got", 32'(got), 32'd4);
        tick;
        check("bp_no_extra", 32'(out_valid), 32'd0);

        // Random requests under a random consumer.
        accepted = 0;
        cyc      = 0;
        hold_v   = 1'b0;
        while ((accepted < 1000 || q.size() != 0) && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (accepted < 1000) && ($urandom_range(0, 4) != 0);
            EXTop     = 3'($urandom_range(0, 7));
            imm       = rand_imm();
            tmpl      = $urandom;
            #1;
            if (hold_v) begin
                check("rnd_hold_valid", 32'(out_valid), 32'd1);
                check("rnd_hold_inst", inst, hold_inst);
                check("rnd_hold_err", 32'(err), 32'(hold_err));
            end
            if (in_valid && in_ready) begin
                q.push_back('{EXTop, imm, tmpl});
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    r = q.pop_front();
                    check_result(r, inst, err);
                end
            end
            hold_v    = out_valid && !out_ready;
            hold_inst = inst;
            hold_err  = err;
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        check("rnd_accepted", 32'(accepted), 32'd1000);
        check("rnd_drained", 32'(q.size()), 32'd0);

        // Reset between clock edges with two requests in flight.
        xfer(3'b111, 32'd0, 32'd0, 1'b0, ri, re);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        EXTop     = 3'b000;
        imm       = 32'd5;
        tmpl      = 32'h0000_0013;
        tick;
        tick;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_inst", inst, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
